// File: rtl/sync_ram_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// sync_ram_rr_arbiter_if
//
// Purpose
//   Bundles the init control and the two requester handshakes of
//   sync_ram_rr_arbiter into one interface.
//
// Signals
//   init_req       master->slave  pulse: restart the zero-fill sweep
//   init_busy      slave->master  high while the zero-fill sweep runs
//   reqN_valid     master->slave  N=0,1: request present
//   reqN_ready     slave->master  N=0,1: request accepted this cycle
//   reqN_write     master->slave  N=0,1: 1 = write, 0 = read
//   reqN_addr      master->slave  N=0,1: word address
//   reqN_wdata     master->slave  N=0,1: write data
//   rspN_valid     slave->master  N=0,1: read data valid, one-cycle pulse
//   rspN_rdata     slave->master  N=0,1: read data, held until next rspN_valid
//
// Modports
//   master : the requester side (drives requests, receives responses)
//   slave  : the arbiter/RAM side
// ----------------------------------------------------------------------------
interface sync_ram_rr_arbiter_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
);

    logic                     init_req;
    logic                     init_busy;

    logic                     req0_valid;
    logic                     req0_ready;
    logic                     req0_write;
    logic [ADDRESS_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0]    req0_wdata;
    logic                     rsp0_valid;
    logic [DATA_WIDTH-1:0]    rsp0_rdata;

    logic                     req1_valid;
    logic                     req1_ready;
    logic                     req1_write;
    logic [ADDRESS_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0]    req1_wdata;
    logic                     rsp1_valid;
    logic [DATA_WIDTH-1:0]    rsp1_rdata;

    modport master (
        output init_req,
        input  init_busy,
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata
    );

    modport slave (
        input  init_req,
        output init_busy,
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata
    );

endinterface

// File: rtl/sync_ram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// sync_ram_rr_arbiter
//
// Purpose
//   Two-port round-robin arbiter in front of one single-port synchronous RAM.
//   Two requesters share the RAM port through valid/ready handshakes; read
//   data comes back one cycle after the handshake on a per-port response
//   strobe. After reset, and on init_req, an init engine zero-fills the RAM.
//
// Parameters
//   DATA_WIDTH     RAM word width in bits
//   ADDRESS_WIDTH  RAM address width; depth = 2**ADDRESS_WIDTH words
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of sync_ram_rr_arbiter_if (init control, two
//          request channels, two response channels)
// ----------------------------------------------------------------------------
module sync_ram_rr_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sync_ram_rr_arbiter_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_ARB  = 1'b1;

    localparam logic [ADDRESS_WIDTH-1:0] CNT_MAX = '1;

    logic [0:0]               state;
    logic [ADDRESS_WIDTH-1:0] init_cnt;
    logic                     prio;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic                     grant0;
    logic                     grant1;
    logic                     rd0_p0;
    logic                     rd1_p0;
    logic                     acc_write_p0;
    logic [ADDRESS_WIDTH-1:0] acc_addr_p0;
    logic [DATA_WIDTH-1:0]    acc_wdata_p0;
    logic                     init_we_p0;

    logic                     rsp0_vld_p1;
    logic                     rsp1_vld_p1;
    logic [DATA_WIDTH-1:0]    rsp0_data_p1;
    logic [DATA_WIDTH-1:0]    rsp1_data_p1;

    // ---- stage p0: arbitration and RAM access selection ----

    // Grants are only issued in ARB. Under contention prio picks the port;
    // a lone valid is always granted. A grant implies the handshake, since
    // ready is never raised without the matching valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_ARB) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = ~prio;
                grant1 = prio;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.init_busy  = (state == ST_INIT);

    always_comb begin
        acc_write_p0 = 1'b0;
        acc_addr_p0  = '0;
        acc_wdata_p0 = '0;
        if (grant1) begin
            acc_write_p0 = bus.req1_write;
            acc_addr_p0  = bus.req1_addr;
            acc_wdata_p0 = bus.req1_wdata;
        end else if (grant0) begin
            acc_write_p0 = bus.req0_write;
            acc_addr_p0  = bus.req0_addr;
            acc_wdata_p0 = bus.req0_wdata;
        end
    end

    assign rd0_p0 = grant0 & ~bus.req0_write;
    assign rd1_p0 = grant1 & ~bus.req1_write;

    // The sweep is held off while rst_n is low so reset never disturbs
    // RAM contents; it starts on the first edge after release.
    assign init_we_p0 = (state == ST_INIT) && rst_n;

    // Control: state, sweep counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            prio     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    // init_req is deliberately ignored here: the sweep
                    // runs to completion without restarting.
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == CNT_MAX) begin
                        state <= ST_ARB;
                    end
                end
                default: begin
                    if (grant0) begin
                        prio <= 1'b1;
                    end else if (grant1) begin
                        prio <= 1'b0;
                    end
                    // A handshake in this same cycle still completes: the
                    // RAM access below does not look at init_req.
                    if (bus.init_req) begin
                        state    <= ST_INIT;
                        init_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // RAM write port: zero-fill during the sweep, otherwise granted writes.
    always_ff @(posedge clk) begin
        if (init_we_p0) begin
            mem[init_cnt] <= '0;
        end else if ((grant0 || grant1) && acc_write_p0) begin
            mem[acc_addr_p0] <= acc_wdata_p0;
        end
    end

    // ---- stage p1: read response registers ----

    // Read data is captured at the handshake edge, giving latency 1. Each
    // port's data register only updates on its own read, so rdata holds
    // between responses. Reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_vld_p1  <= 1'b0;
            rsp1_vld_p1  <= 1'b0;
            rsp0_data_p1 <= '0;
            rsp1_data_p1 <= '0;
        end else begin
            rsp0_vld_p1 <= rd0_p0;
            rsp1_vld_p1 <= rd1_p0;
            if (rd0_p0) begin
                rsp0_data_p1 <= mem[acc_addr_p0];
            end
            if (rd1_p0) begin
                rsp1_data_p1 <= mem[acc_addr_p0];
            end
        end
    end

    assign bus.rsp0_valid = rsp0_vld_p1;
    assign bus.rsp1_valid = rsp1_vld_p1;
    assign bus.rsp0_rdata = rsp0_data_p1;
    assign bus.rsp1_rdata = rsp1_data_p1;

endmodule

// File: tb/tb_sync_ram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sync_ram_rr_arbiter
//
// Purpose
//   Directed bench for sync_ram_rr_arbiter with ADDRESS_WIDTH=4. Reads push
//   their hand-computed data and the cycle it is due into a per-port queue;
//   a monitor pops and checks whenever a response strobe is seen.
//
// Ports
//   none (top-level bench)
// ----------------------------------------------------------------------------
module tb_sync_ram_rr_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sync_ram_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    sync_ram_rr_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push_exp(input int port, input logic [DW-1:0] data);
        exp_t e;
        e.data = data;
        e.due  = cyc + 1;
        if (port == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    endtask

    // Single request on one port; called and returns at posedge+1.
    task automatic req(input int port, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd);
        int   n = 0;
        logic rdy;
        if (port == 0) begin
            bus.req0_valid = 1'b1; bus.req0_write = wr; bus.req0_addr = addr; bus.req0_wdata = wdata;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_write = wr; bus.req1_addr = addr; bus.req1_wdata = wdata;
        end
        forever begin
            @(negedge clk);
            rdy = (port == 0) ? bus.req0_ready : bus.req1_ready;
            if (rdy || n >= 50) break;
            n++;
        end
        check("req_granted", rdy, 1);
        if (rdy && !wr) push_exp(port, exp_rd);
        @(posedge clk);
        #1;
        clear_reqs();
    endtask

    // Holds both ports requesting a harmless write of 0 to address 0 through
    // the sweep: ready must stay low, busy must last 16 cycles, and the first
    // grant afterwards must go to port 0 (prio at its reset value).
    task automatic init_sweep(input string tag);
        int cnt = 0;
        bus.req0_valid = 1'b1; bus.req0_write = 1'b1; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b1; bus.req1_write = 1'b1; bus.req1_addr = '0; bus.req1_wdata = '0;
        forever begin
            @(negedge clk);
            if (!bus.init_busy || cnt >= 40) break;
            cnt++;
            check({tag, "_ready_in_init"}, {bus.req0_ready, bus.req1_ready}, 2'b00);
        end
        check({tag, "_busy_cycles"}, cnt, 16);
        check({tag, "_first_ready0"}, bus.req0_ready, 1);
        check({tag, "_first_ready1"}, bus.req1_ready, 0);
        @(posedge clk);
        #1;
        clear_reqs();
    endtask

    // Response monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.rsp0_valid) begin
                    check("rsp0_expected", q0.size() != 0, 1);
                    if (q0.size() != 0) begin
                        e = q0.pop_front();
                        check("rsp0_rdata", bus.rsp0_rdata, e.data);
                        check("rsp0_latency", cyc, e.due);
                    end
                end
                if (bus.rsp1_valid) begin
                    check("rsp1_expected", q1.size() != 0, 1);
                    if (q1.size() != 0) begin
                        e = q1.pop_front();
                        check("rsp1_rdata", bus.rsp1_rdata, e.data);
                        check("rsp1_latency", cyc, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus.init_req = 1'b0;
        clear_reqs();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_init_busy", bus.init_busy, 1);
        check("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        check("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b00);
        check("rst_rsp0_rdata", bus.rsp0_rdata, 8'h00);
        check("rst_rsp1_rdata", bus.rsp1_rdata, 8'h00);
        idle(2);
        rst_n = 1'b1;

        // 1: sweep length after reset
        init_sweep("t1");

        // 2: write via port 0, read back via port 1
        req(0, 1'b1, 4'd3, 8'hA5, 8'h00);
        req(1, 1'b0, 4'd3, 8'h00, 8'hA5);
        idle(2);

        // 3: contention, grants alternate starting at port 0
        req(0, 1'b1, 4'd1, 8'h11, 8'h00);
        req(1, 1'b1, 4'd2, 8'h22, 8'h00);
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 4'd1;
        bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 4'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t3_ready0", bus.req0_ready, (i % 2) == 0);
            check("t3_ready1", bus.req1_ready, (i % 2) == 1);
            if ((i % 2) == 0) push_exp(0, 8'h11);
            else              push_exp(1, 8'h22);
            @(posedge clk);
            #1;
        end
        clear_reqs();
        idle(3);
        check("t3_rsp0_hold", bus.rsp0_rdata, 8'h11);
        check("t3_rsp1_hold", bus.rsp1_rdata, 8'h22);

        // 5: init_req with a same-cycle read, re-request during sweep ignored
        req(0, 1'b1, 4'd7, 8'h77, 8'h00);
        req(0, 1'b1, 4'd5, 8'h3C, 8'h00);
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 4'd7;
        bus.init_req   = 1'b1;
        @(negedge clk);
        check("t5_ready_with_init", bus.req0_ready, 1);
        if (bus.req0_ready) push_exp(0, 8'h77);
        @(posedge clk);
        #1;
        clear_reqs();
        bus.init_req = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk);
            bus.init_req = (cnt == 4);
            if (!bus.init_busy || cnt >= 40) break;
            cnt++;
        end
        bus.init_req = 1'b0;
        check("t5_busy_cycles", cnt, 16);
        @(posedge clk);
        #1;
        req(0, 1'b0, 4'd5, 8'h00, 8'h00);
        req(1, 1'b0, 4'd7, 8'h00, 8'h00);
        idle(2);

        // 6: reset with a read in flight
        req(1, 1'b1, 4'd9, 8'h99, 8'h00);
        req(0, 1'b1, 4'd10, 8'hAA, 8'h00);
        req(0, 1'b0, 4'd10, 8'h00, 8'hAA);
        idle(2);
        bus.req0_valid = 1'b1; bus.req0_write = 1'b0; bus.req0_addr = 4'd9;
        @(negedge clk);
        check("t6_inflight_ready", bus.req0_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_reqs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_rsp0_valid", bus.rsp0_valid, 0);
            check("t6_rsp0_rdata", bus.rsp0_rdata, 8'h00);
            check("t6_busy", bus.init_busy, 1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        init_sweep("t6");

        // 4: every address reads zero, earlier writes gone
        for (int a = 0; a < 16; a++) begin
            req(a % 2, 1'b0, AW'(a), 8'h00, 8'h00);
        end
        idle(3);
        check("end_q0_empty", q0.size(), 0);
        check("end_q1_empty", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
